eth_frame_tx: RTL and testbench
===============================

// Module: eth_frame_tx
// PURPOSE
//  Ethernet frame generator: the transmit-side counterpart of the packet detector/controller.
//  Serialises one frame per start request onto the byte interface (data[7:0] + control):
//   - 14-byte header: dst MAC, src MAC, type/length
//   - payload pulled from an upstream byte stream, zero-padded to the minimum size
//   - end marker (control=0, data=8'h00), then an inter-frame gap
//  Sits between the frame scheduler and the line-side byte interface.
// PARAMETERS
//  MIN_PAYLOAD  46    minimum payload bytes; shorter payloads are zero-padded
//  MAX_PAYLOAD  1500  maximum payload bytes; larger requests are rejected
//  IFG_CYCLES   12    idle cycles (control=0, data=8'h00) after the end marker
// PORTS
//  clock        in   1   rising-edge clock
//  reset        in   1   reset, synchronous, active-high
//  start        in   1   frame request; accepted only when busy=0
//  dst_mac      in   48  destination MAC; sampled on accepted start
//  src_mac      in   48  source MAC; sampled on accepted start
//  type_length  in   16  type/length field; sampled on accepted start
//  payload_len  in   11  payload byte count, 1..MAX_PAYLOAD; sampled on accepted start
//  pl_data      in   8   payload byte from upstream
//  pl_valid     in   1   pl_data valid
//  pl_ready     out  1   block consumes pl_data this cycle (registered)
//  data         out  8   line byte (registered)
//  control      out  1   1 = frame byte on data; 0 = idle/end marker (registered)
//  busy         out  1   high from accepted start until the gap completes
//  done         out  1   1-cycle pulse: frame sent complete
//  err          out  1   1-cycle pulse: request rejected or payload underrun
// BEHAVIOUR
//  Reset: state IDLE; data=8'h00, control=0, pl_ready=0, busy=0, done=0, err=0.
//   Reset mid-frame aborts on that edge: no end marker, no done, no err.
//  Registered fields: byte counter (11 bit), gap counter.
//  IDLE:
//   - start with payload_len in 1..MAX_PAYLOAD: latch all fields, busy=1 next cycle, -> HEADER.
//   - start with payload_len=0 or >MAX_PAYLOAD: err=1 for one cycle, stay IDLE, busy stays 0.
//  HEADER (14 cycles, control=1), MSB byte first:
//   - dst_mac[47:40] .. dst_mac[7:0], then src_mac[47:40] .. src_mac[7:0],
//     then type_length[15:8], type_length[7:0].
//   - First header byte appears on data the cycle after start was sampled (latency 1).
//   - pl_ready rises during the last header cycle so the payload byte lands back-to-back.
//  PAYLOAD (payload_len cycles):
//   - Handshake: a byte is consumed on a cycle with pl_ready=1 and pl_valid=1; that byte
//     drives data with control=1 the next cycle.
//   - pl_ready=0 after the final byte is consumed.
//   - Underrun (pl_ready=1, pl_valid=0): abort. Next cycle control=0, data=8'h00,
//     err pulse, pl_ready=0, -> GAP. No done.
//  PAD: taken only if payload_len < MIN_PAYLOAD.
//   - Emit (MIN_PAYLOAD - payload_len) bytes of 8'h00 with control=1.
//  END: one cycle control=0, data=8'h00 (end marker); done=1 this cycle; -> GAP.
//  GAP:
//   - IFG_CYCLES cycles with control=0, data=8'h00; busy=1 throughout.
//   - -> IDLE, busy=0.
//  start is ignored whenever busy=1, including the final GAP cycle.
//  Minimum back-to-back spacing: busy falls, then start accepted the same cycle busy=0 is seen.
//  Frame length with control=1: 14 + max(payload_len, MIN_PAYLOAD) cycles.
// TESTING
//  1. Reset, then start with dst=0x0102_0304_0506, src=0xAABB_CCDD_EEFF, tl=0x0800,
//     len=46, pl_valid=1 and bytes 0..45
//     -> 60 control=1 bytes: 01..06, AA..FF, 08 00, 00..2D; then the end marker
//        with done; then 12 idle cycles; busy spans the whole frame and gap.
//  2. len=10, payload bytes 0xF0..0xF9
//     -> 10 payload bytes, then 36 pad bytes of 0x00 with control=1; total 60 frame bytes.
//  3. len=1501 or len=0
//     -> err pulse, busy=0, control stays 0.
//  4. len=100, pl_valid dropped at payload byte 20
//     -> 20 payload bytes sent, then control=0 with err; no done; GAP; busy falls after 12 cycles.
//  5. reset asserted at header byte 7 -> next cycle all outputs at reset values; a new start
//     is accepted right after.
//  6. start held high through a frame -> second frame starts only after busy=0;
//     exactly IFG_CYCLES+1 control=0 cycles between the two frames.

Source files
------------

// File: rtl/eth_frame_tx.sv
// Ethernet frame generator.
// Serialises one frame per accepted start: 14-byte header (dst MAC, src MAC,
// type/length), payload pulled from an upstream byte stream, zero padding up to
// MIN_PAYLOAD, a one-cycle end marker, then IFG_CYCLES idle cycles.
// All outputs are registered; the state register names what is on the outputs now.
module eth_frame_tx #(
    parameter int unsigned MIN_PAYLOAD = 46,
    parameter int unsigned MAX_PAYLOAD = 1500,
    parameter int unsigned IFG_CYCLES  = 12
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [47:0] dst_mac,
    input  logic [47:0] src_mac,
    input  logic [15:0] type_length,
    input  logic [10:0] payload_len,
    input  logic [7:0]  pl_data,
    input  logic        pl_valid,
    output logic        pl_ready,
    output logic [7:0]  data,
    output logic        control,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int unsigned GapW    = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES + 1) : 1;
    localparam logic [10:0] MinLen  = 11'(MIN_PAYLOAD);
    localparam logic [10:0] MaxLen  = 11'(MAX_PAYLOAD);
    localparam logic [10:0] HdrLast = 11'd13;
    localparam logic [GapW-1:0] GapLast = GapW'(IFG_CYCLES);

    typedef enum logic [2:0] {
        StIdle,
        StHeader,
        StPayload,
        StPad,
        StEnd,
        StGap
    } state_e;

    state_e          state_q, state_d;
    // Remaining header bytes, next one to send in the top byte.
    logic [111:0]    hdr_q, hdr_d;
    logic [10:0]     len_q, len_d;
    // Header: index of byte on the line. Payload/pad: bytes of payload+pad sent so far.
    logic [10:0]     cnt_q, cnt_d;
    logic [GapW-1:0] gap_q, gap_d;
    logic [7:0]      data_q, data_d;
    logic            control_q, control_d;
    logic            pl_ready_q, pl_ready_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            err_q, err_d;

    // Cycle in which pl_ready is up: either consume a byte or declare underrun.
    logic            consume;
    logic [10:0]     taken;
    logic [10:0]     taken_next;

    assign taken      = (state_q == StPayload) ? cnt_q : 11'd0;
    assign taken_next = taken + 11'd1;

    // Next-state and registered-output computation.
    always_comb begin
        state_d    = state_q;
        hdr_d      = hdr_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        gap_d      = gap_q;
        data_d     = 8'h00;
        control_d  = 1'b0;
        pl_ready_d = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        consume    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (payload_len == 11'd0 || payload_len > MaxLen) begin
                        err_d = 1'b1;
                    end else begin
                        state_d   = StHeader;
                        hdr_d     = {dst_mac[39:0], src_mac, type_length, 8'h00};
                        len_d     = payload_len;
                        cnt_d     = 11'd0;
                        data_d    = dst_mac[47:40];
                        control_d = 1'b1;
                    end
                end
            end

            StHeader: begin
                if (cnt_q != HdrLast) begin
                    cnt_d      = cnt_q + 11'd1;
                    data_d     = hdr_q[111:104];
                    hdr_d      = {hdr_q[103:0], 8'h00};
                    control_d  = 1'b1;
                    // Raise ready alongside the last header byte so payload follows directly.
                    pl_ready_d = (cnt_q == HdrLast - 11'd1);
                end else begin
                    consume = 1'b1;
                end
            end

            StPayload: begin
                if (pl_ready_q) begin
                    consume = 1'b1;
                end else if (cnt_q < MinLen) begin
                    state_d   = StPad;
                    cnt_d     = cnt_q + 11'd1;
                    control_d = 1'b1;
                end else begin
                    state_d = StEnd;
                    done_d  = 1'b1;
                end
            end

            StPad: begin
                if (cnt_q < MinLen) begin
                    cnt_d     = cnt_q + 11'd1;
                    control_d = 1'b1;
                end else begin
                    state_d = StEnd;
                    done_d  = 1'b1;
                end
            end

            // End marker or underrun-abort cycle; both are followed by the full gap.
            StEnd: begin
                state_d = StGap;
                gap_d   = GapW'(1);
            end

            StGap: begin
                if (gap_q == GapLast) begin
                    state_d = StIdle;
                end else begin
                    gap_d = gap_q + GapW'(1);
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        if (consume) begin
            if (pl_valid) begin
                state_d    = StPayload;
                data_d     = pl_data;
                control_d  = 1'b1;
                cnt_d      = taken_next;
                pl_ready_d = (taken_next < len_q);
            end else begin
                // Underrun: drop to idle line with an error, no done.
                state_d = StEnd;
                err_d   = 1'b1;
            end
        end

        busy_d = (state_d != StIdle);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StIdle;
            hdr_q      <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            gap_q      <= '0;
            data_q     <= 8'h00;
            control_q  <= 1'b0;
            pl_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            hdr_q      <= hdr_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            gap_q      <= gap_d;
            data_q     <= data_d;
            control_q  <= control_d;
            pl_ready_q <= pl_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign pl_ready = pl_ready_q;
    assign data     = data_q;
    assign control  = control_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_eth_frame_tx.sv
// Scoreboard bench for eth_frame_tx: stimulus queues expected line bytes and
// done/err events; a negedge monitor pops and compares whenever they appear.
module tb_eth_frame_tx;

    localparam int MinPl = 46;
    localparam int Ifg   = 12;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [47:0] dst_mac = '0;
    logic [47:0] src_mac = '0;
    logic [15:0] type_length = '0;
    logic [10:0] payload_len = '0;
    logic [7:0]  pl_data = '0;
    logic        pl_valid = 1'b0;
    logic        pl_ready;
    logic [7:0]  data;
    logic        control;
    logic        busy;
    logic        done;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] exp_q[$];   // expected control=1 bytes
    int         ev_q[$];    // expected pulses: 1 = done, 2 = err
    logic [8:0] pl_q[$];    // upstream stream: bit 8 = valid
    bit         pend = 1'b0;

    eth_frame_tx #(
        .MIN_PAYLOAD(46),
        .MAX_PAYLOAD(1500),
        .IFG_CYCLES (12)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .dst_mac    (dst_mac),
        .src_mac    (src_mac),
        .type_length(type_length),
        .payload_len(payload_len),
        .pl_data    (pl_data),
        .pl_valid   (pl_valid),
        .pl_ready   (pl_ready),
        .data       (data),
        .control    (control),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Upstream source: present the queue head, pop it after a handshake edge.
    initial begin
        forever begin
            @(negedge clock);
            if (pend && pl_q.size() > 0) void'(pl_q.pop_front());
            if (pl_q.size() > 0 && pl_q[0][8]) begin
                pl_valid = 1'b1;
                pl_data  = pl_q[0][7:0];
            end else begin
                pl_valid = 1'b0;
                pl_data  = 8'h00;
            end
            pend = pl_ready && pl_valid;
        end
    end

    // Monitor: compare every line byte and every done/err pulse against the queues.
    always @(negedge clock) begin
        if (!reset) begin
            if (control === 1'b1) begin
                if (exp_q.size() == 0) fail_now("unexpected_frame_byte");
                else check("frame_byte", {24'h0, data}, {24'h0, exp_q.pop_front()});
            end else begin
                check("idle_data_zero", {24'h0, data}, 32'h0);
            end
            if (done !== 1'b0 || err !== 1'b0) begin
                if (ev_q.size() == 0) fail_now("unexpected_done_err");
                else check("event_done1_err2", {30'h0, err, done}, ev_q.pop_front());
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    task automatic push_frame(input logic [47:0] d, input logic [47:0] s, input logic [15:0] tl,
                              input int len, input int base, input int drop);
        int nsend;
        for (int i = 0; i < 6; i++) exp_q.push_back(d[47-8*i -: 8]);
        for (int i = 0; i < 6; i++) exp_q.push_back(s[47-8*i -: 8]);
        exp_q.push_back(tl[15:8]);
        exp_q.push_back(tl[7:0]);
        nsend = (drop >= 0) ? drop : len;
        for (int i = 0; i < nsend; i++) begin
            exp_q.push_back(8'(base + i));
            pl_q.push_back({1'b1, 8'(base + i)});
        end
        if (drop >= 0) begin
            pl_q.push_back(9'h000);
            ev_q.push_back(2);
        end else begin
            for (int i = len; i < MinPl; i++) exp_q.push_back(8'h00);
            ev_q.push_back(1);
        end
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (busy === 1'b1 && cyc < 5000) begin
            cyc++;
            @(negedge clock);
        end
        if (cyc >= 5000) fail_now("busy_never_fell");
    endtask

    task automatic frame(input string name, input logic [47:0] d, input logic [47:0] s,
                         input logic [15:0] tl, input int len, input int base, input int drop);
        int cyc;
        int exp_busy;
        push_frame(d, s, tl, len, base, drop);
        dst_mac     = d;
        src_mac     = s;
        type_length = tl;
        payload_len = 11'(len);
        start       = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_idle(cyc);
        exp_busy = (drop >= 0) ? 14 + drop + 1 + Ifg : 14 + ((len > MinPl) ? len : MinPl) + 1 + Ifg;
        check({name, "_busy_cycles"}, cyc, exp_busy);
        if (drop >= 0) pl_q.delete();
    endtask

    task automatic bad_len(input int len);
        ev_q.push_back(2);
        payload_len = 11'(len);
        start       = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("reject_busy_low", {31'h0, busy}, 32'h0);
        check("reject_control_low", {31'h0, control}, 32'h0);
        @(negedge clock);
        check("reject_err_one_cycle", {31'h0, err}, 32'h0);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_data"}, {24'h0, data}, 32'h0);
        check({name, "_control"}, {31'h0, control}, 32'h0);
        check({name, "_pl_ready"}, {31'h0, pl_ready}, 32'h0);
        check({name, "_busy"}, {31'h0, busy}, 32'h0);
        check({name, "_done"}, {31'h0, done}, 32'h0);
        check({name, "_err"}, {31'h0, err}, 32'h0);
    endtask

    initial begin
        int gaps;
        int cyc;
        int guard;

        // Reset state.
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check_reset_outputs("reset");
        reset = 1'b0;
        @(negedge clock);

        // Minimum-size frame, no padding.
        frame("t1", 48'h0102_0304_0506, 48'hAABB_CCDD_EEFF, 16'h0800, 46, 8'h00, -1);
        @(negedge clock);

        // Short payload padded to 46.
        frame("t2", 48'h1111_2222_3333, 48'h4444_5555_6666, 16'h0806, 10, 8'hF0, -1);
        @(negedge clock);

        // Rejected lengths.
        bad_len(1501);
        bad_len(0);

        // Underrun at payload byte 20.
        frame("t4", 48'hDEAD_BEEF_0001, 48'h0000_1234_5678, 16'h0064, 100, 8'h40, 20);
        @(negedge clock);

        // Reset in the middle of the header, then start immediately afterwards.
        push_frame(48'h0A0B_0C0D_0E0F, 48'h1020_3040_5060, 16'h88B5, 46, 8'h60, -1);
        dst_mac     = 48'h0A0B_0C0D_0E0F;
        src_mac     = 48'h1020_3040_5060;
        type_length = 16'h88B5;
        payload_len = 11'd46;
        start       = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (7) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check_reset_outputs("midreset");
        exp_q.delete();
        ev_q.delete();
        pl_q.delete();
        reset = 1'b0;
        frame("t5", 48'h0202_0303_0404, 48'h0505_0606_0707, 16'h86DD, 47, 8'h20, -1);
        @(negedge clock);

        // start held high across two frames: gap between them is IFG + 1 idle cycle.
        push_frame(48'hA1A2_A3A4_A5A6, 48'hB1B2_B3B4_B5B6, 16'h0800, 46, 8'h80, -1);
        push_frame(48'hA1A2_A3A4_A5A6, 48'hB1B2_B3B4_B5B6, 16'h0800, 46, 8'hC0, -1);
        dst_mac     = 48'hA1A2_A3A4_A5A6;
        src_mac     = 48'hB1B2_B3B4_B5B6;
        type_length = 16'h0800;
        payload_len = 11'd46;
        start       = 1'b1;
        guard       = 0;
        while (done !== 1'b1 && guard < 300) begin
            guard++;
            @(negedge clock);
        end
        if (guard >= 300) fail_now("t6_first_done_missing");
        gaps = 0;
        @(negedge clock);
        while (control !== 1'b1 && gaps < 100) begin
            gaps++;
            @(negedge clock);
        end
        check("t6_idle_between_frames", gaps, Ifg + 1);
        start = 1'b0;
        wait_idle(cyc);
        repeat (3) @(negedge clock);
        check("t6_no_third_frame", {31'h0, busy}, 32'h0);

        check("scoreboard_bytes_drained", exp_q.size(), 0);
        check("scoreboard_events_drained", ev_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
